config_loader: RTL and testbench

//  Bitstream loader that sits directly upstream of the tile configuration shift-register chain.

---
 rtl/config_loader_pkg.sv | 29 ++
 rtl/config_serializer.sv | 39 +++
 rtl/config_loader.sv | 140 ++++++++++++++
 tb/tb_config_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// The CRC states exist only when CONFIG_LOADER_CRC_EN is defined.
package config_loader_pkg;

  localparam int unsigned CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT,
`ifdef CONFIG_LOADER_CRC_EN
    ST_WAIT_CRC,
    ST_CHECK,
    ST_ERROR,
`endif
    ST_DONE
  } loader_state_t;

  // One serial CRC-8 step, MSB-first feedback.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/config_serializer.sv
// Word shift register that feeds the configuration chain LSB-first,
// tracking the position of the current bit within the word.
module config_serializer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic                  serial_bit,
  output logic                  word_empty
);

  localparam int unsigned BIT_POS_W = $clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] shreg;
  logic [BIT_POS_W-1:0]  bit_pos;

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      shreg   <= '0;
      bit_pos <= '0;
    end else if (load) begin
      shreg   <= word_in;
      bit_pos <= '0;
    end else if (shift) begin
      shreg   <= {1'b0, shreg[WORD_WIDTH-1:1]};
      bit_pos <= bit_pos + 1'b1;
    end
  end

  // word_empty marks the shift that drains the final bit of the word.
  always_comb begin
    serial_bit = shreg[0];
    word_empty = (bit_pos == BIT_POS_W'(WORD_WIDTH - 1));
  end

endmodule

// File: rtl/config_loader.sv
// Host-to-chain bitstream loader: serialises words LSB-first onto the config chain.
// Optional trailer CRC-8 check is built when CONFIG_LOADER_CRC_EN is defined.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = 64
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BIT_CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(CHAIN_LENGTH);

  loader_state_t          state, next_state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   load, shift, ser_bit, word_empty;
  logic                   last_bit, done_q, start_accept;

`ifdef CONFIG_LOADER_CRC_EN
  logic [CRC_W-1:0] crc, trailer;
  logic             error_q;
`endif

  config_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .config_clock (config_clock),
    .config_nreset(config_nreset),
    .load         (load),
    .shift        (shift),
    .word_in      (word_data),
    .serial_bit   (ser_bit),
    .word_empty   (word_empty)
  );

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) state <= ST_IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state   = state;
    word_ready   = 1'b0;
    chain_enable = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_WAIT_WORD;
      ST_WAIT_WORD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          load       = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        chain_enable = 1'b1;
        shift        = 1'b1;
        // Chain length wins over word boundary: leftover word bits are dropped.
        if (bit_cnt == LAST_BIT) begin
`ifdef CONFIG_LOADER_CRC_EN
          next_state = ST_WAIT_CRC;
`else
          next_state = ST_DONE;
`endif
        end else if (word_empty) begin
          next_state = ST_WAIT_WORD;
        end
      end
`ifdef CONFIG_LOADER_CRC_EN
      ST_WAIT_CRC: begin
        word_ready = 1'b1;
        if (word_valid) next_state = ST_CHECK;
      end
      ST_CHECK: next_state = (crc == trailer) ? ST_DONE : ST_ERROR;
      ST_ERROR: if (start) next_state = ST_WAIT_WORD;
`endif
      default: next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  always_comb begin
    busy = (state == ST_WAIT_WORD) || (state == ST_SHIFT);
`ifdef CONFIG_LOADER_CRC_EN
    busy = busy || (state == ST_WAIT_CRC) || (state == ST_CHECK);
`endif
    start_accept = start && !abort && !busy;
    chain_data   = (state == ST_SHIFT) ? ser_bit : last_bit;
    done         = done_q;
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (start_accept || abort)                bit_cnt <= '0;
      else if (shift && (bit_cnt != FULL_CNT))  bit_cnt <= bit_cnt + 1'b1;
      if (shift) last_bit <= ser_bit;
      if (start_accept)                                    done_q <= 1'b0;
      else if ((next_state == ST_DONE) && (state != ST_DONE)) done_q <= 1'b1;
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      crc     <= CRC_INIT;
      trailer <= '0;
      error_q <= 1'b0;
    end else begin
      if (start_accept) crc <= CRC_INIT;
      else if (shift)   crc <= crc8_step(crc, ser_bit);
      if ((state == ST_WAIT_CRC) && word_valid) trailer <= word_data[CRC_W-1:0];
      if (start_accept)                                      error_q <= 1'b0;
      else if ((next_state == ST_ERROR) && (state != ST_ERROR)) error_q <= 1'b1;
    end
  end

  always_comb error = error_q;
`else
  always_comb error = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: scoreboard of expected chain bits plus
// chain-register models for a 64-bit and a 12-bit chain.
module tb_config_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, word_valid = 1'b0, use_b = 1'b0;
  logic [7:0] word_data = '0;

  logic ready_a, data_a, en_a, busy_a, done_a, error_a;
  logic ready_b, data_b, en_b, busy_b, done_b, error_b;
  logic word_ready, chain_data, chain_enable, busy, done, error;

  int unsigned checks = 0, errors = 0, en_cnt = 0, pushed = 0, cur_len = 64;
  bit          exp_q[$];
  logic [7:0]  crc_exp = '0;
  logic [63:0] model_a = '0;
  logic [11:0] model_b = '0;

  always #5 clk = ~clk;

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(64)) dut_a (
    .config_clock(clk), .config_nreset(rst_n),
    .start(start & ~use_b), .abort(abort & ~use_b),
    .word_data(word_data), .word_valid(word_valid & ~use_b),
    .word_ready(ready_a), .chain_data(data_a), .chain_enable(en_a),
    .busy(busy_a), .done(done_a), .error(error_a));

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(12)) dut_b (
    .config_clock(clk), .config_nreset(rst_n),
    .start(start & use_b), .abort(abort & use_b),
    .word_data(word_data), .word_valid(word_valid & use_b),
    .word_ready(ready_b), .chain_data(data_b), .chain_enable(en_b),
    .busy(busy_b), .done(done_b), .error(error_b));

  assign word_ready   = use_b ? ready_b : ready_a;
  assign chain_data   = use_b ? data_b  : data_a;
  assign chain_enable = use_b ? en_b    : en_a;
  assign busy         = use_b ? busy_b  : busy_a;
  assign done         = use_b ? done_b  : done_a;
  assign error        = use_b ? error_b : error_a;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [63:0] words_model(input logic [7:0] base);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = base + 8'(i);
    return m;
  endfunction

  // Chain model and scoreboard pop on every enabled chain cycle.
  initial begin
    bit exp_bit;
    forever begin
      @(negedge clk);
      if (chain_enable === 1'b1) begin
        if (use_b) model_b = {chain_data, model_b[11:1]};
        else       model_a = {chain_data, model_a[63:1]};
        en_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL chain_bit unexpected enable, data=%b, required no enable", chain_data);
        end else begin
          exp_bit = exp_q.pop_front();
          if (chain_data !== exp_bit) begin
            errors++;
            $display("FAIL chain_bit #%0d got %b required %b", en_cnt, chain_data, exp_bit);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // All tasks start and end on a falling edge.
  task automatic pulse_start();
    exp_q.delete();
    pushed  = 0;
    crc_exp = 8'h00;
    cur_len = use_b ? 12 : 64;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit is_data);
    int unsigned n;
    word_data  = w;
    word_valid = 1'b1;
    n = 0;
    while (word_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (word_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_word timeout, word_ready=%b required 1", word_ready);
      word_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (is_data) begin
        for (int i = 0; i < 8; i++) begin
          if (pushed < cur_len) begin
            exp_q.push_back(w[i]);
            crc_exp = crc8(crc_exp, w[i]);
            pushed++;
          end
        end
      end
      @(negedge clk);
      word_valid = 1'b0;
    end
  endtask

  task automatic finish_load(input logic [63:0] exp_model, input int unsigned en0,
                             input string name);
    int unsigned n;
    logic [63:0] obs;
`ifdef CONFIG_LOADER_CRC_EN
    send_word(crc_exp, 1'b0);
`endif
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status done/error/busy=%b%b%b required 100", name, done, error, busy);
    end
    checks++;
    if (en_cnt - en0 != cur_len) begin
      errors++;
      $display("FAIL %s_enables got %0d required %0d", name, en_cnt - en0, cur_len);
    end
    obs = use_b ? {52'b0, model_b} : model_a;
    if (use_b) exp_model = {52'b0, exp_model[11:0]};
    checks++;
    if (obs !== exp_model) begin
      errors++;
      $display("FAIL %s_contents got %h required %h", name, obs, exp_model);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover got %0d pending bits required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ready_a, data_a, en_a, busy_a, done_a, error_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a got %b required 000000",
               {ready_a, data_a, en_a, busy_a, done_a, error_a});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready_b, data_b, en_b, busy_b, done_b, error_b} !== 6'b0) begin
      errors++;
      $display("FAIL reset_b got %b required 000000",
               {ready_b, data_b, en_b, busy_b, done_b, error_b});
    end
  endtask

  task automatic test_back_to_back();
    int unsigned en0;
    use_b = 1'b0;
    en0 = en_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_state busy/done/ready=%b%b%b required 101", busy, done, word_ready);
    end
    for (int i = 0; i < 8; i++) send_word(8'(i + 1), 1'b1);
`ifndef CONFIG_LOADER_CRC_EN
    repeat (7) @(negedge clk);
    checks++;
    if (chain_enable !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL last_bit enable/done=%b%b required 10", chain_enable, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || chain_enable !== 1'b0) begin
      errors++;
      $display("FAIL done_latency done/enable=%b%b required 10", done, chain_enable);
    end
`endif
    finish_load(words_model(8'h01), en0, "b2b");
  endtask

  task automatic test_short_chain();
    int unsigned en0;
    use_b = 1'b1;
    en0 = en_cnt;
    pulse_start();
    send_word(8'hFF, 1'b1);
    send_word(8'hA5, 1'b1);
    finish_load(64'h5FF, en0, "short");
    repeat (6) @(negedge clk);
    checks++;
    if (en_cnt - en0 != 12 || word_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_saturate enables=%0d ready=%b required 12 and 0", en_cnt - en0, word_ready);
    end
    use_b = 1'b0;
  endtask

  task automatic test_stall();
    int unsigned en0, n;
    en0 = en_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(8'(i + 1), 1'b1);
    n = 0;
    while (word_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (chain_enable !== 1'b0 || word_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle%0d enable/ready=%b%b required 01", c, chain_enable, word_ready);
      end
      @(negedge clk);
    end
    for (int i = 3; i < 8; i++) send_word(8'(i + 1), 1'b1);
    finish_load(words_model(8'h01), en0, "stall");
  endtask

  task automatic test_abort();
    int unsigned en0;
    pulse_start();
    send_word(8'h3C, 1'b1);
    send_word(8'hC3, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    checks++;
    if ({busy, done, error, word_ready, chain_enable} !== 5'b0) begin
      errors++;
      $display("FAIL abort_idle busy/done/error/ready/enable=%b required 00000",
               {busy, done, error, word_ready, chain_enable});
    end
    en0 = en_cnt;
    pulse_start();
    for (int i = 0; i < 8; i++) send_word(8'hA0 + 8'(i), 1'b1);
    finish_load(words_model(8'hA0), en0, "reload");
  endtask

  task automatic test_start_ignored();
    int unsigned en0;
    en0 = en_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(8'(i + 1), 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || chain_enable !== 1'b1) begin
      errors++;
      $display("FAIL busy_start busy/enable=%b%b required 11", busy, chain_enable);
    end
    for (int i = 3; i < 8; i++) send_word(8'(i + 1), 1'b1);
    finish_load(words_model(8'h01), en0, "busy_start");
    pulse_start();
    send_word(8'h77, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({busy, word_ready, done} !== 3'b0) begin
        errors++;
        $display("FAIL abort_start_cycle%0d busy/ready/done=%b required 000", c,
                 {busy, word_ready, done});
      end
      @(negedge clk);
    end
  endtask

`ifdef CONFIG_LOADER_CRC_EN
  task automatic test_crc();
    int unsigned n;
    for (int t = 0; t < 2; t++) begin
      pulse_start();
      for (int i = 0; i < 8; i++) send_word(8'h00, 1'b1);
      send_word((t == 0) ? 8'h00 : 8'h5A, 1'b0);
      n = 0;
      while (done !== 1'b1 && error !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (t == 0 && (done !== 1'b1 || error !== 1'b0)) begin
        errors++;
        $display("FAIL crc_good done/error=%b%b required 10", done, error);
      end else if (t == 1 && (done !== 1'b0 || error !== 1'b1)) begin
        errors++;
        $display("FAIL crc_bad done/error=%b%b required 01", done, error);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_short_chain();
    test_stall();
    test_abort();
    test_start_ignored();
`ifdef CONFIG_LOADER_CRC_EN
    test_crc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
